// File: rtl/bwt_pkg.sv
// Shared BWT types: default symbol width, symbol type and the inverse-BWT state encoding.
package bwt_pkg;

    localparam int unsigned BWT_SYM_W = 8;

    typedef logic [BWT_SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RANK = 2'd1,
        WALK = 2'd2
    } ibwt_state_t;

endpackage

// File: rtl/ibwt_lf_unit.sv
// Combinational LF-mapping for one row:
// LF[i] = #{j<len : L[j] < L[i]} + #{j<i : L[j] == L[i]}.
module ibwt_lf_unit
    import bwt_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned SYM_W = BWT_SYM_W,
    localparam int unsigned LEN_W = $clog2(N + 1),
    localparam int unsigned IDX_W = $clog2(N),
    localparam int unsigned CNT_W = $clog2(N) + 1
) (
    input  logic [N-1:0][SYM_W-1:0] l_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [IDX_W-1:0]        lf_c_o
);

    logic [SYM_W-1:0] cur;
    logic [CNT_W-1:0] cnt_less;
    logic [CNT_W-1:0] cnt_eq;

    // Smaller symbols anywhere in the valid range, plus equal symbols strictly before row i.
    always_comb begin
        cur      = l_i[idx_i];
        cnt_less = '0;
        cnt_eq   = '0;
        for (int j = 0; j < int'(N); j++) begin
            if ((LEN_W'(j) < len_i) && (l_i[j] < cur)) begin
                cnt_less = cnt_less + CNT_W'(1);
            end
            if ((IDX_W'(j) < idx_i) && (l_i[j] == cur)) begin
                cnt_eq = cnt_eq + CNT_W'(1);
            end
        end
        lf_c_o = IDX_W'(cnt_less + cnt_eq);
    end

endmodule

// File: rtl/ibwt_decode.sv
// Inverse BWT decoder: rank pass builds LF[], walk pass emits symbols back to front.
// Define IBWT_CHECK_EN to flag walks that revisit a row (input not a valid BWT).
module ibwt_decode
    import bwt_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned SYM_W = BWT_SYM_W,
    localparam int unsigned LEN_W = $clog2(N + 1),
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [N-1:0][SYM_W-1:0] data_in_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic [IDX_W-1:0]        primary_idx_i,
    output logic [N-1:0][SYM_W-1:0] data_out_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    ibwt_state_t              state_q, state_d;
    logic [N-1:0][SYM_W-1:0]  l_q, l_d;
    logic [N-1:0][SYM_W-1:0]  dout_q, dout_d;
    logic [N-1:0][IDX_W-1:0]  lf_q, lf_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [IDX_W-1:0]         pidx_q, pidx_d;
    logic [IDX_W-1:0]         i_q, i_d;
    logic [IDX_W-1:0]         p_q, p_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
`ifdef IBWT_CHECK_EN
    logic [N-1:0]             vis_q, vis_d;
`endif

    logic [LEN_W-1:0]         len_clip;
    logic [IDX_W-1:0]         lf_c;
    logic                     range_ok;

    assign len_clip = (len_i > LEN_W'(N)) ? LEN_W'(N) : len_i;
    assign range_ok = (len_q != '0) && (LEN_W'(pidx_q) < len_q);

    ibwt_lf_unit #(
        .N     (N),
        .SYM_W (SYM_W)
    ) u_lf (
        .l_i    (l_q),
        .len_i  (len_q),
        .idx_i  (i_q),
        .lf_c_o (lf_c)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        dout_d  = dout_q;
        lf_d    = lf_q;
        len_d   = len_q;
        pidx_d  = pidx_q;
        i_d     = i_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef IBWT_CHECK_EN
        vis_d   = vis_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    l_d     = data_in_i;
                    len_d   = len_clip;
                    pidx_d  = primary_idx_i;
                    dout_d  = '0;
                    err_d   = 1'b0;
                    i_d     = '0;
                    state_d = RANK;
                    // Bad ranges finish after one cycle without ever looking busy.
                    busy_d  = (len_clip != '0) && (LEN_W'(primary_idx_i) < len_clip);
`ifdef IBWT_CHECK_EN
                    vis_d   = '0;
`endif
                end
            end
            RANK: begin
                if (!range_ok) begin
                    done_d  = 1'b1;
                    err_d   = (len_q != '0);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lf_d[i_q] = lf_c;
                    if (LEN_W'(i_q) == len_q - LEN_W'(1)) begin
                        state_d = WALK;
                        p_d     = pidx_q;
                        i_d     = IDX_W'(len_q - LEN_W'(1));
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end
            end
            WALK: begin
                dout_d[i_q] = l_q[p_q];
                p_d         = lf_q[p_q];
`ifdef IBWT_CHECK_EN
                if (vis_q[p_q]) begin
                    err_d = 1'b1;
                end
                vis_d[p_q] = 1'b1;
`endif
                if (i_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    i_d = i_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            l_q     <= '0;
            dout_q  <= '0;
            lf_q    <= '0;
            len_q   <= '0;
            pidx_q  <= '0;
            i_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IBWT_CHECK_EN
            vis_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            dout_q  <= dout_d;
            lf_q    <= lf_d;
            len_q   <= len_d;
            pidx_q  <= pidx_d;
            i_q     <= i_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IBWT_CHECK_EN
            vis_q   <= vis_d;
`endif
        end
    end

    assign data_out_o = dout_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
